// File: rtl/read_response_engine.sv
// Receive side of the c0 read path: decodes control-poll lines into the ctrl_* handshake
// and counts/checksums run-read lines until the expected line count has arrived.
package read_response_engine_pkg;
  typedef enum logic [2:0] {
    AFU_IDLE = 3'd0,
    AFU_CTRL = 3'd1,
    AFU_RUN  = 3'd2,
    AFU_DONE = 3'd3
  } e_afu_state;
endpackage

module read_response_engine
  import read_response_engine_pkg::*;
#(
  parameter logic [15:0] READ_CTRL_MDATA   = 16'h0001,
  parameter logic [15:0] READ_RUN_MDATA    = 16'h0002,
  parameter logic [31:0] CONTROL_IDLE      = 32'd0,
  parameter logic [31:0] CONTROL_START_RUN = 32'd1,
  parameter logic [31:0] CONTROL_STOP      = 32'd2
) (
  input  logic         clk,
  input  logic         reset,
  input  e_afu_state   afu_state,
  input  logic         rx_valid,
  input  logic [15:0]  rx_mdata,
  input  logic [511:0] rx_data,
  output logic         ctrl_valid,
  output logic [31:0]  ctrl_code,
  output logic [41:0]  ctrl_rd_addr,
  output logic [31:0]  ctrl_num_cls,
  output logic         ctrl_ack,
  output logic [31:0]  run_count,
  output logic [63:0]  run_checksum,
  output logic         run_complete,
  output logic [15:0]  stray_count
);

  typedef enum logic [1:0] {S_IDLE, S_CTRL_WAIT, S_RUN, S_DONE} e_state;

  e_state       state_reg, state_next;
  logic         s1_valid_reg;
  logic [15:0]  s1_mdata_reg;
  logic [511:0] s1_data_reg;
  e_afu_state   s1_afu_reg;
  logic [32:0]  expected_reg;

  // afu_state is staged with the response so every decision sees a consistent pair
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_mdata_reg <= '0;
      s1_data_reg  <= '0;
      s1_afu_reg   <= AFU_IDLE;
    end else begin
      s1_valid_reg <= rx_valid;
      s1_mdata_reg <= rx_mdata;
      s1_data_reg  <= rx_data;
      s1_afu_reg   <= afu_state;
    end
  end

  logic [63:0] word [8];
  logic [63:0] line_fold;

  for (genvar gi = 0; gi < 8; gi++) begin : g_word
    assign word[gi] = s1_data_reg[gi*64 +: 64];
  end

  always_comb begin
    line_fold = '0;
    for (int i = 0; i < 8; i++) line_fold = line_fold ^ word[i];
  end

  logic [31:0] line_code;
  logic [41:0] line_addr;
  logic [31:0] line_num;
  logic        ctrl_hit, run_hit, stray_hit, start_hit, stop_hit, last_hit;
  logic [31:0] count_inc;

  assign line_code = s1_data_reg[31:0];
  assign line_addr = s1_data_reg[105:64];
  assign line_num  = s1_data_reg[159:128];

  assign ctrl_hit  = s1_valid_reg && (s1_mdata_reg == READ_CTRL_MDATA) && (s1_afu_reg == AFU_CTRL);
  assign run_hit   = s1_valid_reg && (s1_mdata_reg == READ_RUN_MDATA) && (state_reg == S_RUN);
  assign stray_hit = s1_valid_reg && !ctrl_hit && !run_hit;
  assign start_hit = ctrl_hit && (line_code == CONTROL_START_RUN);
  assign stop_hit  = ctrl_hit && (line_code == CONTROL_STOP);
  assign count_inc = (run_count == 32'hFFFF_FFFF) ? run_count : run_count + 32'd1;
  assign last_hit  = run_hit && ({1'b0, count_inc} == expected_reg);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (s1_afu_reg == AFU_CTRL) state_next = S_CTRL_WAIT;
      S_CTRL_WAIT: state_next = S_CTRL_WAIT;
      S_RUN:       if (last_hit) state_next = S_DONE;
      S_DONE:      if (s1_afu_reg == AFU_CTRL) state_next = S_CTRL_WAIT;
      default:     state_next = S_IDLE;
    endcase
    if (start_hit) state_next = S_RUN;
    if (stop_hit)  state_next = S_IDLE;
    // Leaving to AFU_IDLE wins, but the run results are kept for software to read
    if (s1_afu_reg == AFU_IDLE) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_valid   <= 1'b0;
      ctrl_ack     <= 1'b0;
      ctrl_code    <= '0;
      ctrl_rd_addr <= '0;
      ctrl_num_cls <= '0;
      run_count    <= '0;
      run_checksum <= '0;
      run_complete <= 1'b0;
      stray_count  <= '0;
      expected_reg <= '0;
    end else begin
      ctrl_valid <= ctrl_hit && (line_code != CONTROL_IDLE);
      ctrl_ack   <= ctrl_hit;
      if (ctrl_hit) begin
        ctrl_code    <= line_code;
        ctrl_rd_addr <= line_addr;
        ctrl_num_cls <= line_num;
      end
      // Request side reads start..start+num_cls inclusive, hence the +1
      if (start_hit) begin
        expected_reg <= {1'b0, line_num} + 33'd1;
        run_count    <= '0;
        run_checksum <= '0;
        run_complete <= 1'b0;
      end
      if (run_hit) begin
        run_count    <= count_inc;
        run_checksum <= run_checksum ^ line_fold;
        if (last_hit) run_complete <= 1'b1;
      end
      if (stray_hit && (stray_count != 16'hFFFF)) stray_count <= stray_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_read_response_engine.sv
// Directed bench for read_response_engine: stimulus pushes expected output snapshots,
// a negedge monitor pops and compares them whenever the DUT shows a response.
module tb_read_response_engine;
  import read_response_engine_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  e_afu_state   afu_state;
  logic         rx_valid;
  logic [15:0]  rx_mdata;
  logic [511:0] rx_data;
  logic         ctrl_valid, ctrl_ack, run_complete;
  logic [31:0]  ctrl_code, ctrl_num_cls, run_count;
  logic [41:0]  ctrl_rd_addr;
  logic [63:0]  run_checksum;
  logic [15:0]  stray_count;

  read_response_engine dut (
    .clk(clk), .reset(reset), .afu_state(afu_state),
    .rx_valid(rx_valid), .rx_mdata(rx_mdata), .rx_data(rx_data),
    .ctrl_valid(ctrl_valid), .ctrl_code(ctrl_code), .ctrl_rd_addr(ctrl_rd_addr),
    .ctrl_num_cls(ctrl_num_cls), .ctrl_ack(ctrl_ack), .run_count(run_count),
    .run_checksum(run_checksum), .run_complete(run_complete), .stray_count(stray_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        v;
    logic        a;
    logic [31:0] code;
    logic [41:0] addr;
    logic [31:0] num;
    logic [31:0] cnt;
    logic [63:0] cks;
    logic        done;
    logic [15:0] stray;
  } snap_t;

  snap_t       exp_q[$];
  int          cyc_q[$];
  snap_t       m;
  logic [32:0] m_exp;
  logic        m_run;
  int          n_pass = 0, n_total = 0;
  bit          mon_en = 0;
  snap_t       prev = '0;

  function automatic snap_t cur_snap();
    snap_t s;
    s = {ctrl_valid, ctrl_ack, ctrl_code, ctrl_rd_addr, ctrl_num_cls,
         run_count, run_checksum, run_complete, stray_count};
    return s;
  endfunction

  // Every accepted response produces an ack pulse or a counter change
  always @(negedge clk) begin
    snap_t c, e;
    int    lat;
    c = cur_snap();
    if (mon_en && (c.v || c.a || c.cnt != prev.cnt || c.cks != prev.cks ||
                   c.done != prev.done || c.stray != prev.stray)) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event got %h want none", c);
      end else begin
        e   = exp_q.pop_front();
        lat = cyc - cyc_q.pop_front();
        if (c == e && lat == 2) begin
          n_pass++;
          $display("txn ok: lat=%0d ack=%0b valid=%0b code=%0d cnt=%0d cks=%h done=%0b stray=%0d",
                   lat, c.a, c.v, c.code, c.cnt, c.cks, c.done, c.stray);
        end else begin
          $display("FAIL scoreboard got %h lat %0d want %h lat 2", c, lat, e);
        end
      end
    end
    prev = c;
  end

  function automatic logic [511:0] mk_ctrl(logic [31:0] code, logic [41:0] addr, logic [31:0] num);
    logic [511:0] d;
    d = '0;
    d[31:0]    = code;
    d[105:64]  = addr;
    d[159:128] = num;
    return d;
  endfunction

  function automatic logic [511:0] mk_run(logic [63:0] w0, logic [63:0] w7);
    logic [511:0] d;
    d = '0;
    d[63:0]    = w0;
    d[511:448] = w7;
    return d;
  endfunction

  task automatic send(input logic [15:0] md, input logic [511:0] d);
    snap_t       e;
    logic [63:0] f;
    rx_valid = 1'b1;
    rx_mdata = md;
    rx_data  = d;
    e   = m;
    e.v = 1'b0;
    e.a = 1'b0;
    if (afu_state == AFU_IDLE) m_run = 1'b0;
    if (md == 16'h0001 && afu_state == AFU_CTRL) begin
      e.a    = 1'b1;
      e.v    = (d[31:0] != 32'd0);
      e.code = d[31:0];
      e.addr = d[105:64];
      e.num  = d[159:128];
      if (d[31:0] == 32'd1) begin
        m_exp  = {1'b0, d[159:128]} + 33'd1;
        e.cnt  = '0;
        e.cks  = '0;
        e.done = 1'b0;
        m_run  = 1'b1;
      end else if (d[31:0] == 32'd2) begin
        m_run = 1'b0;
      end
    end else if (md == 16'h0002 && m_run) begin
      f = '0;
      for (int i = 0; i < 8; i++) f = f ^ d[i*64 +: 64];
      if (e.cnt != 32'hFFFF_FFFF) e.cnt = e.cnt + 32'd1;
      e.cks = e.cks ^ f;
      if ({1'b0, e.cnt} == m_exp) begin
        e.done = 1'b1;
        m_run  = 1'b0;
      end
    end else if (e.stray != 16'hFFFF) begin
      e.stray = e.stray + 16'd1;
    end
    m = e;
    exp_q.push_back(e);
    cyc_q.push_back(cyc);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s got %h want %h", name, got, want);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_total++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain got %0d pending want 0", exp_q.size());
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  task automatic do_reset();
    snap_t s;
    mon_en   = 0;
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    m     = '0;
    m_exp = '0;
    m_run = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    s = cur_snap();
    n_total++;
    if (s == '0) n_pass++;
    else $display("FAIL reset_state got %h want 0", s);
    mon_en = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] d;
    reset     = 1'b1;
    afu_state = AFU_IDLE;
    rx_valid  = 1'b0;
    rx_mdata  = '0;
    rx_data   = '0;
    repeat (2) @(negedge clk);
    do_reset();

    afu_state = AFU_CTRL;
    @(negedge clk);
    send(16'h0001, mk_ctrl(32'd0, 42'h0, 32'd0));
    drain();
    chk("idle_poll_valid", ctrl_valid, 0);

    send(16'h0001, mk_ctrl(32'd1, 42'h100, 32'd3));
    drain();
    chk("start_rd_addr", ctrl_rd_addr, 64'h100);
    chk("start_num_cls", ctrl_num_cls, 64'd3);

    afu_state = AFU_RUN;
    send(16'h0002, mk_run(64'd1, 64'd0));
    send(16'h0002, mk_run(64'd2, 64'd0));
    send(16'h0002, mk_run(64'd4, 64'd0));
    send(16'h0002, mk_run(64'd8, 64'd0));
    drain();
    chk("run_count4", run_count, 64'd4);
    chk("run_checksum", run_checksum, 64'hF);
    chk("run_complete", run_complete, 64'd1);

    send(16'h0002, mk_run(64'd16, 64'd0));
    drain();
    chk("extra_line_stray", stray_count, 64'd1);
    chk("extra_line_count", run_count, 64'd4);

    send(16'h00FF, mk_run(64'd5, 64'd5));
    send(16'h0001, mk_ctrl(32'd1, 42'h0, 32'd9));
    drain();
    chk("stray_total", stray_count, 64'd3);
    chk("stray_ctrl_num_kept", ctrl_num_cls, 64'd3);

    afu_state = AFU_CTRL;
    send(16'h0001, mk_ctrl(32'd2, 42'h0, 32'd0));
    drain();
    chk("stop_code", ctrl_code, 64'd2);
    send(16'h0002, mk_run(64'd1, 64'd0));
    drain();
    chk("run_after_stop_stray", stray_count, 64'd4);

    // Ignored bits above code and rd_addr are filled to check the field extraction
    d = mk_ctrl(32'd1, 42'h2AB_CDEF_0123, 32'd3);
    d[63:32]   = 32'hDEAD_BEEF;
    d[127:106] = '1;
    send(16'h0001, d);
    drain();
    chk("start2_code", ctrl_code, 64'd1);
    chk("start2_rd_addr", ctrl_rd_addr, 64'h2AB_CDEF_0123);

    afu_state = AFU_RUN;
    send(16'h0002, mk_run(64'h11, 64'h22));
    send(16'h0002, mk_run(64'h40, 64'h0));
    drain();
    chk("run2_checksum", run_checksum, 64'h73);
    chk("run2_complete", run_complete, 64'd0);

    do_reset();
    send(16'h0002, mk_run(64'd1, 64'd0));
    drain();
    chk("post_reset_stray", stray_count, 64'd1);
    chk("post_reset_count", run_count, 64'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
